// File: rtl/mult_top.sv
// Sequential radix-2 shift-and-add unsigned multiplier with a start/busy/done handshake.
// One partial-product step per cycle for exactly WIDTH cycles; the product register holds until the next completion.
module mult_top #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   acc_step_s;

  // Conditional add of the shifted multiplicand for the current multiplier bit.
  always_comb begin
    if (mplier_q[0]) begin
      acc_step_s = acc_q + mcand_q;
    end else begin
      acc_step_s = acc_q;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_step_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last step: capture the final sum so P is valid during FINISH.
        if (cnt_q == CW'(1)) begin
          p_d     = acc_step_s;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_top.sv
// Directed self-checking bench for mult_top (WIDTH=8): latency, hold, abort and input-isolation behaviour.
module tb_mult_top;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int vectors = 0;
  int errs    = 0;

  mult_top #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts an operation at the current negedge and follows it to completion.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                        input logic [15:0] prev_p, input bit disturb, input string tag);
    int lat;
    int busy_n;
    int extra_done;
    int extra_busy;
    bit held_ok;
    A = a;
    B = b;
    start = 1'b1;
    lat = 0;
    busy_n = 0;
    extra_done = 0;
    extra_busy = 0;
    held_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      if (P !== prev_p) held_ok = 1'b0;
      if (disturb && lat == 3) begin
        start = 1'b1;
        A = 8'd9;
        B = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, busy_n, 8);
    check({tag, " P"}, {16'd0, P}, {16'd0, exp_p});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " P_held_during_op"}, {31'd0, held_ok}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) extra_done++;
      if (busy !== 1'b0) extra_busy++;
    end
    check({tag, " extra_done"}, extra_done, 0);
    check({tag, " extra_busy"}, extra_busy, 0);
    check({tag, " P_after"}, {16'd0, P}, {16'd0, exp_p});
  endtask

  initial begin
    int idle_bad;
    int abort_done;
    reset = 1'b1;
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset P", {16'd0, P}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    idle_bad = 0;
    A = 8'd3;
    B = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || P !== 16'd0) idle_bad++;
    end
    check("idle no activity", idle_bad, 0);

    run_op(8'd5,   8'd3,   16'd15,    16'd0,     1'b0, "5x3");
    run_op(8'd12,  8'd8,   16'd96,    16'd15,    1'b0, "12x8");
    run_op(8'd15,  8'd7,   16'd105,   16'd96,    1'b0, "15x7");
    run_op(8'd255, 8'd255, 16'hFE01,  16'd105,   1'b0, "255x255");
    run_op(8'd100, 8'd0,   16'd0,     16'hFE01,  1'b0, "100x0");
    run_op(8'd0,   8'd77,  16'd0,     16'd0,     1'b0, "0x77");
    run_op(8'd5,   8'd3,   16'd15,    16'd0,     1'b1, "5x3 disturbed");

    // Abort mid-operation with reset.
    A = 8'd200;
    B = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort P", {16'd0, P}, 32'd0);
    abort_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) abort_done++;
      @(negedge clk);
    end
    check("abort no done", abort_done, 0);
    run_op(8'd7, 8'd6, 16'd42, 16'd0, 1'b0, "7x6 after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
